regfile_wb_sink: RTL and testbench
==================================

Name: regfile_wb_sink

Overview:
- Pipeline register file that receives the writeback stage's (rwe, destination index, dataout) triple and serves the decode stage through two combinational read ports (rs, rt).
- Holds a per-register scoreboard of in-flight writes. Decode registers each issued writer. Writeback retires it. The block raises a stall when decode reads an operand whose producer has not reached writeback.
- Sits between writeback and decode, closing the write-read loop of the 5-stage MIPS pipeline.

Parameters:
- DATA_W, 32, register width.
- NREGS, 32, number of architectural registers; index width is 5.
- SB_CNT_W, 2, width of each per-register in-flight counter; maximum value is 2**SB_CNT_W-1.

Ports:
- clock  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- wb_rwe  input  1  writeback register-write enable
- wb_dst  input  5  writeback destination index (rt, rd or 31 for JAL/JALR)
- wb_data  input  32  writeback data (ALU result, DMEM data or PC+8)
- rs_addr  input  5  decode read index A
- rt_addr  input  5  decode read index B
- rs_data  output  32  read data A, combinational
- rt_data  output  32  read data B, combinational
- iss_valid  input  1  decode presents an instruction this cycle
- iss_rwe  input  1  issued instruction will write a register
- iss_dst  input  5  destination of the issued instruction
- iss_rs_used  input  1  issued instruction reads rs
- iss_rt_used  input  1  issued instruction reads rt
- stall  output  1  combinational; decode must hold and re-present
- sb_err  output  1  sticky retire-without-issue error flag

Behaviour:
- Reset (asynchronous, active-low; clears mid-operation with no completion of a pending write):
  - all 32 registers = 0
  - all counters = 0
  - sb_err = 0
  - stall = 0 and read outputs = 0 follow combinationally
- Register 0:
  - reads always return 0
  - writes are discarded
  - never pending
  - issues with iss_dst = 0 do not count
- Write: on a rising clock edge, when wb_rwe=1 and wb_dst≠0, reg[wb_dst] <= wb_data. Latency is 1 cycle to storage.
- Read: rs_data = reg[rs_addr], with bypass rules under Optional Feature. Same for rt.
- Retire: retire = wb_rwe && wb_dst≠0.
- Issue: issue = iss_valid && !stall && iss_rwe && iss_dst≠0.
- Counter update per register per edge:
  - issue only: +1
  - retire only: −1
  - issue and retire to the same register in the same cycle: unchanged
- Retire when the counter is 0: counter stays 0 and sb_err <= 1. sb_err stays set until reset.
- Pending(r), with bypass: cnt[r] > 1, or (cnt[r] == 1 and no retire to r this cycle).
- Pending(r), without bypass: cnt[r] ≠ 0.
- stall = iss_valid && ((iss_rs_used && Pending(rs_addr)) || (iss_rt_used && Pending(rt_addr)) || (iss_rwe && cnt[iss_dst] == max)).
- Saturation: the max-count term prevents counter overflow.
- While stall=1, the instruction is not counted. Decode holds all iss_* and address inputs stable.
- Multiple in-flight writers to the same register: the last retire clears pending. Writeback order is in program order, so the final value is correct.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - read ports are write-through: if wb_rwe && wb_dst == addr && addr ≠ 0, read data = wb_data
  - Pending uses the bypass form; an operand retiring this cycle does not stall
- Undefined:
  - reads return stored contents only
  - Pending uses cnt ≠ 0, so a consumer stalls through the retire cycle and reads the committed value on the next cycle (+1 cycle RAW penalty)

Decomposition:
- Package mips_rf_pkg:
  - REG_IDX_W = 5
  - NREGS = 32
  - REG_ZERO = 5'd0
  - REG_RA = 5'd31
  - DATA_W = 32
- Sub-module rf_scoreboard:
  - contains the counter array, the pending logic and sb_err
  - the top level holds the storage array, the read muxes and the bypass

Test Plan:
- Reset, then read every register → rs_data = rt_data = 0, stall = 0, sb_err = 0.
- wb_rwe=1, wb_dst=5, wb_data=0xDEADBEEF, with rs_addr=5 in the same cycle:
  - WB_BYPASS_EN defined → rs_data = 0xDEADBEEF in that cycle
  - undefined → rs_data = 0 in that cycle and 0xDEADBEEF on the next
- Write to r0 with 0x1234 → r0 reads 0. Issue with iss_dst=0 → no counting and no stall.
- Issue iss_dst=8, then present iss_rs_used=1 with rs_addr=8 → stall = 1 until the retire of r8.
  - with bypass, stall drops in the retire cycle
  - without bypass, stall drops one cycle later
- Issue iss_dst=31 three times without retire (cnt = 3), then a fourth issue to 31 → stall = 1 and the count stays 3. Three retires to 31 → count 0 and no stall.
- Retire to r9 with cnt = 0 → sb_err = 1 and cnt stays 0. Assert reset_n low mid-stream → all registers, counters and sb_err clear immediately.

Source files
------------

// File: rtl/mips_rf_pkg.sv
// Shared constants for the MIPS register file slice: index width, register count and special indices.
package mips_rf_pkg;
    localparam int REG_IDX_W = 5;
    localparam int NREGS     = 32;
    localparam int DATA_W    = 32;

    localparam logic [REG_IDX_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_IDX_W-1:0] REG_RA   = 5'd31;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register in-flight writer counters, operand-pending/stall logic and sticky retire error.
// Pending form depends on WB_BYPASS_EN (retiring operand is not pending when defined).
module rf_scoreboard
    import mips_rf_pkg::*;
#(
    parameter int NREGS    = mips_rf_pkg::NREGS,
    parameter int SB_CNT_W = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wb_rwe,
    input  logic [REG_IDX_W-1:0] wb_dst,
    input  logic                 iss_valid,
    input  logic                 iss_rwe,
    input  logic [REG_IDX_W-1:0] iss_dst,
    input  logic                 iss_rs_used,
    input  logic [REG_IDX_W-1:0] rs_addr,
    input  logic                 iss_rt_used,
    input  logic [REG_IDX_W-1:0] rt_addr,
    output logic                 stall,
    output logic                 sb_err
);

    localparam logic [SB_CNT_W-1:0] CNT_MAX = '1;
    localparam logic [SB_CNT_W-1:0] CNT_ONE = SB_CNT_W'(1);

    logic [SB_CNT_W-1:0] cnt_q [NREGS];
    logic                retire;
    logic                issue;
    logic                rs_pend;
    logic                rt_pend;
    logic                dst_full;
    logic [NREGS-1:0]    issue_oh;
    logic [NREGS-1:0]    retire_oh;

    assign retire = wb_rwe && (wb_dst != REG_ZERO);

    always_comb begin
        rs_pend  = 1'b0;
        rt_pend  = 1'b0;
`ifdef WB_BYPASS_EN
        rs_pend = (cnt_q[rs_addr] > CNT_ONE) ||
                  ((cnt_q[rs_addr] == CNT_ONE) && !(retire && (wb_dst == rs_addr)));
        rt_pend = (cnt_q[rt_addr] > CNT_ONE) ||
                  ((cnt_q[rt_addr] == CNT_ONE) && !(retire && (wb_dst == rt_addr)));
`else
        rs_pend = (cnt_q[rs_addr] != '0);
        rt_pend = (cnt_q[rt_addr] != '0);
`endif
        // A full counter blocks another writer, so counters can never wrap.
        dst_full = (cnt_q[iss_dst] == CNT_MAX);
        stall    = iss_valid && ((iss_rs_used && rs_pend) ||
                                 (iss_rt_used && rt_pend) ||
                                 (iss_rwe && dst_full));
    end

    assign issue     = iss_valid && !stall && iss_rwe && (iss_dst != REG_ZERO);
    assign issue_oh  = issue  ? (NREGS'(1) << iss_dst) : '0;
    assign retire_oh = retire ? (NREGS'(1) << wb_dst)  : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                cnt_q[r] <= '0;
            end
            sb_err <= 1'b0;
        end else begin
            if (retire && (cnt_q[wb_dst] == '0)) begin
                sb_err <= 1'b1;
            end
            for (int r = 1; r < NREGS; r++) begin
                if (issue_oh[r] && !retire_oh[r]) begin
                    cnt_q[r] <= cnt_q[r] + 1'b1;
                end else if (retire_oh[r] && !issue_oh[r] && (cnt_q[r] != '0)) begin
                    cnt_q[r] <= cnt_q[r] - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wb_sink.sv
// Register file written by writeback and read combinationally by decode, with in-flight scoreboard.
// Define WB_BYPASS_EN for write-through reads and same-cycle release of retiring operands.
module regfile_wb_sink
    import mips_rf_pkg::*;
#(
    parameter int DATA_W   = mips_rf_pkg::DATA_W,
    parameter int NREGS    = mips_rf_pkg::NREGS,
    parameter int SB_CNT_W = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 wb_rwe,
    input  logic [REG_IDX_W-1:0] wb_dst,
    input  logic [DATA_W-1:0]    wb_data,
    input  logic [REG_IDX_W-1:0] rs_addr,
    input  logic [REG_IDX_W-1:0] rt_addr,
    output logic [DATA_W-1:0]    rs_data,
    output logic [DATA_W-1:0]    rt_data,
    input  logic                 iss_valid,
    input  logic                 iss_rwe,
    input  logic [REG_IDX_W-1:0] iss_dst,
    input  logic                 iss_rs_used,
    input  logic                 iss_rt_used,
    output logic                 stall,
    output logic                 sb_err
);

    logic [DATA_W-1:0] mem_q [NREGS];
    logic              wr_en;

    assign wr_en = wb_rwe && (wb_dst != REG_ZERO);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wb_dst] <= wb_data;
        end
    end

    // r0 is never written, but the explicit index check keeps reads at zero regardless.
    always_comb begin
        rs_data = '0;
        rt_data = '0;
        if (rs_addr != REG_ZERO) rs_data = mem_q[rs_addr];
        if (rt_addr != REG_ZERO) rt_data = mem_q[rt_addr];
`ifdef WB_BYPASS_EN
        if (wr_en && (wb_dst == rs_addr)) rs_data = wb_data;
        if (wr_en && (wb_dst == rt_addr)) rt_data = wb_data;
`endif
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .SB_CNT_W (SB_CNT_W)
    ) u_sb (
        .clock       (clock),
        .reset_n     (reset_n),
        .wb_rwe      (wb_rwe),
        .wb_dst      (wb_dst),
        .iss_valid   (iss_valid),
        .iss_rwe     (iss_rwe),
        .iss_dst     (iss_dst),
        .iss_rs_used (iss_rs_used),
        .rs_addr     (rs_addr),
        .iss_rt_used (iss_rt_used),
        .rt_addr     (rt_addr),
        .stall       (stall),
        .sb_err      (sb_err)
    );

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Directed scoreboard bench for regfile_wb_sink; expectations follow WB_BYPASS_EN when defined.
module tb_regfile_wb_sink;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        wb_rwe;
    logic [4:0]  wb_dst;
    logic [31:0] wb_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        iss_valid;
    logic        iss_rwe;
    logic [4:0]  iss_dst;
    logic        iss_rs_used;
    logic        iss_rt_used;
    logic        stall;
    logic        sb_err;

    always #5 clock = ~clock;

    regfile_wb_sink dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wb_rwe      (wb_rwe),
        .wb_dst      (wb_dst),
        .wb_data     (wb_data),
        .rs_addr     (rs_addr),
        .rt_addr     (rt_addr),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .iss_valid   (iss_valid),
        .iss_rwe     (iss_rwe),
        .iss_dst     (iss_dst),
        .iss_rs_used (iss_rs_used),
        .iss_rt_used (iss_rt_used),
        .stall       (stall),
        .sb_err      (sb_err)
    );

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [3:0] M_RS = 4'b0001;
    localparam logic [3:0] M_RT = 4'b0010;
    localparam logic [3:0] M_ST = 4'b0100;
    localparam logic [3:0] M_ER = 4'b1000;

    typedef struct {
        string       nm;
        logic [3:0]  m;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        st;
        logic        er;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push_exp(input string nm, input logic [3:0] m, input logic [31:0] rs,
                            input logic [31:0] rt, input logic st, input logic er);
        exp_t e;
        e.nm = nm; e.m = m; e.rs = rs; e.rt = rt; e.st = st; e.er = er;
        sbq.push_back(e);
    endtask

    task automatic idle();
        wb_rwe = 1'b0; wb_dst = '0; wb_data = '0;
        rs_addr = '0; rt_addr = '0;
        iss_valid = 1'b0; iss_rwe = 1'b0; iss_dst = '0;
        iss_rs_used = 1'b0; iss_rt_used = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_to(input logic [4:0] d);
        idle();
        iss_valid = 1'b1; iss_rwe = 1'b1; iss_dst = d;
    endtask

    // Monitor: everything queued for this cycle is compared on the falling edge.
    always @(negedge clock) begin
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            if (e.m[0]) begin
                checks++;
                if (rs_data !== e.rs) begin
                    failures++;
                    $display("FAIL %s rs_data got=%h want=%h", e.nm, rs_data, e.rs);
                end
            end
            if (e.m[1]) begin
                checks++;
                if (rt_data !== e.rt) begin
                    failures++;
                    $display("FAIL %s rt_data got=%h want=%h", e.nm, rt_data, e.rt);
                end
            end
            if (e.m[2]) begin
                checks++;
                if (stall !== e.st) begin
                    failures++;
                    $display("FAIL %s stall got=%b want=%b", e.nm, stall, e.st);
                end
            end
            if (e.m[3]) begin
                checks++;
                if (sb_err !== e.er) begin
                    failures++;
                    $display("FAIL %s sb_err got=%b want=%b", e.nm, sb_err, e.er);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout pending=%0d", sbq.size());
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        reset_n = 1'b0;
        step(); rs_addr = 5'd3; rt_addr = 5'd31;
        push_exp("rst_hold", M_RS | M_RT | M_ST | M_ER, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); reset_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            step(); idle();
            rs_addr = 5'(i); rt_addr = 5'(31 - i);
            push_exp("rst_read", M_RS | M_RT | M_ST | M_ER, 32'h0, 32'h0, 1'b0, 1'b0);
        end

        // write r5, read on rs
        step(); issue_to(5'd5);
        push_exp("iss_r5", M_ST, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); idle(); wb_rwe = 1'b1; wb_dst = 5'd5; wb_data = 32'hDEADBEEF; rs_addr = 5'd5;
        push_exp("wb_r5_same", M_RS | M_ER, BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 1'b0);
        step(); idle(); rs_addr = 5'd5;
        push_exp("wb_r5_next", M_RS | M_ER, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);

        // write r7, read on rt
        step(); issue_to(5'd7);
        push_exp("iss_r7", M_ST, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); idle(); wb_rwe = 1'b1; wb_dst = 5'd7; wb_data = 32'h0BADF00D;
        rs_addr = 5'd5; rt_addr = 5'd7;
        push_exp("wb_r7_same", M_RS | M_RT, 32'hDEADBEEF, BYP ? 32'h0BADF00D : 32'h0, 1'b0, 1'b0);
        step(); idle(); rs_addr = 5'd5; rt_addr = 5'd7;
        push_exp("wb_r7_next", M_RS | M_RT, 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 1'b0);

        // r0 is hardwired
        step(); idle(); wb_rwe = 1'b1; wb_dst = 5'd0; wb_data = 32'h1234;
        push_exp("wb_r0_same", M_RS | M_RT, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); idle();
        push_exp("wb_r0_next", M_RS | M_ER, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); issue_to(5'd0);
        push_exp("iss_r0", M_ST, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rs_used = 1'b1; iss_rt_used = 1'b1;
        push_exp("use_r0", M_ST, 32'h0, 32'h0, 1'b0, 1'b0);

        // RAW on r8; stalled consumer also writes r12 and must be counted once
        step(); issue_to(5'd8);
        push_exp("iss_r8", M_ST, 32'h0, 32'h0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step(); issue_to(5'd12); iss_rs_used = 1'b1; rs_addr = 5'd8;
            if (k == 2) begin
                wb_rwe = 1'b1; wb_dst = 5'd8; wb_data = 32'h88880008;
                push_exp("raw_r8_retire", M_RS | M_ST, BYP ? 32'h88880008 : 32'h0, 32'h0,
                         BYP ? 1'b0 : 1'b1, 1'b0);
            end else begin
                push_exp("raw_r8_wait", M_ST, 32'h0, 32'h0, 1'b1, 1'b0);
            end
        end
        step();
`ifdef WB_BYPASS_EN
        idle(); rs_addr = 5'd8;
        push_exp("raw_r8_after", M_RS, 32'h88880008, 32'h0, 1'b0, 1'b0);
`else
        issue_to(5'd12); iss_rs_used = 1'b1; rs_addr = 5'd8;
        push_exp("raw_r8_after", M_RS | M_ST, 32'h88880008, 32'h0, 1'b0, 1'b0);
`endif
        step(); idle(); iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd12;
        push_exp("pend_r12", M_ST, 32'h0, 32'h0, 1'b1, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd12;
        wb_rwe = 1'b1; wb_dst = 5'd12; wb_data = 32'h0000000C;
        push_exp("pend_r12_retire", M_ST, 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd12;
        push_exp("pend_r12_clear", M_RS | M_ST | M_ER, 32'h0000000C, 32'h0, 1'b0, 1'b0);

        // rt operand path on r10
        step(); issue_to(5'd10);
        push_exp("iss_r10", M_ST, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); idle(); iss_valid = 1'b1; rs_addr = 5'd10; rt_addr = 5'd10;
        push_exp("unused_r10", M_ST, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rt_used = 1'b1; rt_addr = 5'd10;
        push_exp("rt_r10_wait", M_ST, 32'h0, 32'h0, 1'b1, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rt_used = 1'b1; rt_addr = 5'd10;
        wb_rwe = 1'b1; wb_dst = 5'd10; wb_data = 32'h0000A0A0;
        push_exp("rt_r10_retire", M_RT | M_ST, 32'h0, BYP ? 32'h0000A0A0 : 32'h0,
                 BYP ? 1'b0 : 1'b1, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rt_used = 1'b1; rt_addr = 5'd10;
        push_exp("rt_r10_clear", M_RT | M_ST, 32'h0, 32'h0000A0A0, 1'b0, 1'b0);

        // saturate r31 at three writers
        for (int k = 0; k < 3; k++) begin
            step(); issue_to(5'd31);
            push_exp("sat_iss", M_ST, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            step(); issue_to(5'd31);
            push_exp("sat_full", M_ST, 32'h0, 32'h0, 1'b1, 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            step(); idle(); wb_rwe = 1'b1; wb_dst = 5'd31; wb_data = 32'h00001F00 + 32'(k);
            push_exp("sat_ret", M_ER, 32'h0, 32'h0, 1'b0, 1'b0);
        end
        step(); idle(); iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd31;
        push_exp("sat_one_left", M_ST, 32'h0, 32'h0, 1'b1, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd31;
        wb_rwe = 1'b1; wb_dst = 5'd31; wb_data = 32'h00001F02;
        push_exp("sat_last_ret", M_ST, 32'h0, 32'h0, BYP ? 1'b0 : 1'b1, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd31;
        push_exp("sat_clear", M_RS | M_ST | M_ER, 32'h00001F02, 32'h0, 1'b0, 1'b0);

        // retire without issue on r9
        step(); idle(); wb_rwe = 1'b1; wb_dst = 5'd9; wb_data = 32'h00000099;
        push_exp("err_ret", M_ER, 32'h0, 32'h0, 1'b0, 1'b0);
        step(); idle(); iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd9;
        push_exp("err_set", M_RS | M_ST | M_ER, 32'h00000099, 32'h0, 1'b0, 1'b1);
        step(); idle();
        push_exp("err_sticky", M_ER, 32'h0, 32'h0, 1'b0, 1'b1);

        // reset in the middle of a pending write with r20 in flight
        step(); issue_to(5'd20);
        push_exp("iss_r20", M_ST, 32'h0, 32'h0, 1'b0, 1'b1);
        step(); idle(); wb_rwe = 1'b1; wb_dst = 5'd5; wb_data = 32'h00005555;
        iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd20;
        push_exp("pre_rst", M_ST | M_ER, 32'h0, 32'h0, 1'b1, 1'b1);
        @(negedge clock); #1;
        reset_n = 1'b0; rt_addr = 5'd7;
        push_exp("in_rst", M_RS | M_RT | M_ST | M_ER, 32'h0, 32'h0, 1'b0, 1'b0);
        @(negedge clock); #1;
        idle(); reset_n = 1'b1;
        iss_valid = 1'b1; iss_rs_used = 1'b1; rs_addr = 5'd20; rt_addr = 5'd5;
        push_exp("post_rst", M_RS | M_RT | M_ST | M_ER, 32'h0, 32'h0, 1'b0, 1'b0);

        step(); idle();
        step();
        @(negedge clock); #1;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
